// File: rtl/fifo_pkg.sv
// Shared FIFO definitions: default address width, pointer width and Gray/binary
// conversion helpers used by the read-pointer logic and its checkers.
package fifo_pkg;

    localparam int ASIZE_DEF = 4;
    localparam int PTR_W     = ASIZE_DEF + 1;

    function automatic logic [31:0] bin2gray(input logic [31:0] b);
        return b ^ (b >> 1);
    endfunction

    function automatic logic [31:0] gray2bin(input logic [31:0] g);
        logic [31:0] b;
        b = 32'd0;
        for (int i = 31; i >= 0; i--) begin
            b[i] = ^(g >> i);
        end
        return b;
    endfunction

endpackage

// File: rtl/gray2bin.sv
// Combinational Gray-to-binary converter (XOR prefix from the MSB down).
module gray2bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray_i,
    output logic [WIDTH-1:0] bin_o
);

    // Each binary bit is the XOR of all Gray bits at or above it
    always_comb begin
        bin_o = '0;
        for (int i = 0; i < WIDTH; i++) begin
            bin_o[i] = ^(gray_i >> i);
        end
    end

endmodule

// File: rtl/rptr_empty.sv
// Read-side pointer, empty flag and sticky underflow for an async FIFO.
// Define RPTR_EMPTY_LEVEL_EN to compile in the fill-level and almost-empty logic.
module rptr_empty
    import fifo_pkg::*;
#(
    parameter int ASIZE     = ASIZE_DEF,
    parameter int AE_THRESH = 2
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             rinc,
    input  logic [ASIZE:0]   rq2_wptr,
    input  logic             rclr_err,
    output logic             rempty,
    output logic [ASIZE-1:0] raddr,
    output logic [ASIZE:0]   rptr,
    output logic [ASIZE:0]   rlevel,
    output logic             ralmost_empty,
    output logic             runderflow
);

    localparam int PW = ASIZE + 1;

    logic [PW-1:0] rbin_q, rbin_d;
    logic [PW-1:0] rptr_q, rptr_d;
    logic          rempty_q, rempty_d;
    logic          runder_q, runder_d;
    logic          rinc_ok_s;

    // Next pointer, empty and underflow state; a read while empty is ignored
    always_comb begin
        rinc_ok_s = rinc & ~rempty_q;
        rbin_d    = rbin_q + {{ASIZE{1'b0}}, rinc_ok_s};
        rptr_d    = PW'(bin2gray(32'(rbin_d)));
        rempty_d  = (rptr_d == rq2_wptr);
        if (rinc && rempty_q) begin
            runder_d = 1'b1;
        end else if (rclr_err) begin
            runder_d = 1'b0;
        end else begin
            runder_d = runder_q;
        end
    end

    // Pointer and flag registers
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rbin_q   <= '0;
            rptr_q   <= '0;
            rempty_q <= 1'b1;
            runder_q <= 1'b0;
        end else begin
            rbin_q   <= rbin_d;
            rptr_q   <= rptr_d;
            rempty_q <= rempty_d;
            runder_q <= runder_d;
        end
    end

    assign rempty     = rempty_q;
    assign raddr      = rbin_q[ASIZE-1:0];
    assign rptr       = rptr_q;
    assign runderflow = runder_q;

`ifdef RPTR_EMPTY_LEVEL_EN
    localparam logic [PW-1:0] DEPTH_C = PW'(2 ** ASIZE);

    logic [PW-1:0] wbin_s;
    logic [PW-1:0] lvl_raw_s;
    logic [PW-1:0] rlevel_q, rlevel_d;
    logic          ralmost_q, ralmost_d;

    gray2bin #(.WIDTH(PW)) u_gray2bin (
        .gray_i (rq2_wptr),
        .bin_o  (wbin_s)
    );

    // Level against the post-read pointer, saturated at full depth
    always_comb begin
        lvl_raw_s = wbin_s - rbin_d;
        if (lvl_raw_s > DEPTH_C) begin
            rlevel_d = DEPTH_C;
        end else begin
            rlevel_d = lvl_raw_s;
        end
        ralmost_d = (rlevel_d <= PW'(AE_THRESH));
    end

    // Level and almost-empty registers
    always_ff @(posedge rclk) begin
        if (rrst) begin
            rlevel_q  <= '0;
            ralmost_q <= 1'b1;
        end else begin
            rlevel_q  <= rlevel_d;
            ralmost_q <= ralmost_d;
        end
    end

    assign rlevel        = rlevel_q;
    assign ralmost_empty = ralmost_q;
`else
    assign rlevel        = '0;
    assign ralmost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_rptr_empty.sv
// Directed self-checking bench for rptr_empty (ASIZE=4, AE_THRESH=2).
module tb_rptr_empty;

`ifdef RPTR_EMPTY_LEVEL_EN
    localparam bit LV = 1'b1;
`else
    localparam bit LV = 1'b0;
`endif

    logic       rclk;
    logic       rrst;
    logic       rinc;
    logic [4:0] rq2_wptr;
    logic       rclr_err;
    logic       rempty;
    logic [3:0] raddr;
    logic [4:0] rptr;
    logic [4:0] rlevel;
    logic       ralmost_empty;
    logic       runderflow;

    int checks;
    int errors;
    int rb;

    rptr_empty #(.ASIZE(4), .AE_THRESH(2)) dut (
        .rclk          (rclk),
        .rrst          (rrst),
        .rinc          (rinc),
        .rq2_wptr      (rq2_wptr),
        .rclr_err      (rclr_err),
        .rempty        (rempty),
        .raddr         (raddr),
        .rptr          (rptr),
        .rlevel        (rlevel),
        .ralmost_empty (ralmost_empty),
        .runderflow    (runderflow)
    );

    initial rclk = 1'b0;
    always #5 rclk = ~rclk;

    task automatic tick();
        @(posedge rclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [4:0] g(input int b);
        logic [4:0] v;
        v = 5'(b);
        return v ^ (v >> 1);
    endfunction

    initial begin
        checks   = 0;
        errors   = 0;
        rrst     = 1'b1;
        rinc     = 1'b0;
        rclr_err = 1'b0;
        rq2_wptr = 5'b00000;
        tick();
        rrst = 1'b0;
        chk("rst_empty", 32'(rempty), 32'd1);
        chk("rst_rptr", 32'(rptr), 32'd0);
        chk("rst_raddr", 32'(raddr), 32'd0);
        chk("rst_level", 32'(rlevel), 32'd0);
        chk("rst_almost", 32'(ralmost_empty), 32'(LV));
        chk("rst_under", 32'(runderflow), 32'd0);

        // Three entries become visible
        rq2_wptr = 5'b00010;
        tick();
        chk("w3_empty", 32'(rempty), 32'd0);
        chk("w3_level", 32'(rlevel), LV ? 32'd3 : 32'd0);
        chk("w3_almost", 32'(ralmost_empty), 32'd0);
        chk("rd0_raddr", 32'(raddr), 32'd0);

        rinc = 1'b1;
        tick();
        chk("rd1_raddr", 32'(raddr), 32'd1);
        chk("rd1_rptr", 32'(rptr), 32'b00001);
        chk("rd1_empty", 32'(rempty), 32'd0);
        chk("rd1_level", 32'(rlevel), LV ? 32'd2 : 32'd0);
        chk("rd1_almost", 32'(ralmost_empty), 32'(LV));
        tick();
        chk("rd2_raddr", 32'(raddr), 32'd2);
        chk("rd2_rptr", 32'(rptr), 32'b00011);
        chk("rd2_empty", 32'(rempty), 32'd0);
        tick();
        chk("rd3_rptr", 32'(rptr), 32'b00010);
        chk("rd3_raddr", 32'(raddr), 32'd3);
        chk("rd3_empty", 32'(rempty), 32'd1);
        chk("rd3_level", 32'(rlevel), 32'd0);
        chk("rd3_under", 32'(runderflow), 32'd0);

        // Reads while empty
        tick();
        tick();
        chk("uf_rptr", 32'(rptr), 32'b00010);
        chk("uf_raddr", 32'(raddr), 32'd3);
        chk("uf_flag", 32'(runderflow), 32'd1);
        rclr_err = 1'b1;
        tick();
        chk("uf_setwins", 32'(runderflow), 32'd1);
        rinc = 1'b0;
        tick();
        chk("uf_clear", 32'(runderflow), 32'd0);
        rclr_err = 1'b0;

        // 32 reads with the writer kept four entries ahead
        rb = 3;
        rq2_wptr = g(rb + 4);
        tick();
        chk("wr_prime_empty", 32'(rempty), 32'd0);
        rinc = 1'b1;
        for (int k = 0; k < 32; k++) begin
            rq2_wptr = g(rb + 4);
            tick();
            rb = (rb + 1) % 32;
            chk("wr_raddr", 32'(raddr), 32'(rb % 16));
            chk("wr_rptr", 32'(rptr), 32'(g(rb)));
            chk("wr_empty", 32'(rempty), 32'd0);
            chk("wr_level", 32'(rlevel), LV ? 32'd3 : 32'd0);
            if (rb == 16) chk("wr_addr_wrap", 32'(raddr), 32'd0);
            if (rb == 31) chk("wr_ptr_top", 32'(rptr), 32'b10000);
            if (rb == 0)  chk("wr_ptr_wrap", 32'(rptr), 32'b00000);
        end

        // Drain to rbin=7, then reset mid-read
        rq2_wptr = g(8);
        for (int k = 0; k < 4; k++) tick();
        chk("pre_rst_raddr", 32'(raddr), 32'd7);
        chk("pre_rst_empty", 32'(rempty), 32'd0);
        chk("pre_rst_level", 32'(rlevel), LV ? 32'd1 : 32'd0);
        rrst = 1'b1;
        tick();
        chk("mid_rst_rptr", 32'(rptr), 32'd0);
        chk("mid_rst_raddr", 32'(raddr), 32'd0);
        chk("mid_rst_empty", 32'(rempty), 32'd1);
        chk("mid_rst_under", 32'(runderflow), 32'd0);
        chk("mid_rst_level", 32'(rlevel), 32'd0);
        rrst = 1'b0;
        rinc = 1'b0;
        tick();
        chk("post_rst_empty", 32'(rempty), 32'd0);
        chk("post_rst_level", 32'(rlevel), LV ? 32'd8 : 32'd0);
        chk("post_rst_almost", 32'(ralmost_empty), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
